// File: rtl/timer_int_pkg.sv
// timer_int_pkg: FSM state encodings and timeout counter width shared by the timer interrupt arbiter and register decode
package timer_int_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        CLEAR    = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;
    localparam int TMO_W = 8;
endpackage

// File: rtl/timer_int_prio_sel.sv
// timer_int_prio_sel: picks one pending channel, lowest index first or rotating from rr_ptr when TIMER_INT_RR_EN is defined
module timer_int_prio_sel #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic [N_CH-1:0] pend,
`ifdef TIMER_INT_RR_EN
    input  logic [ID_W-1:0] rr_ptr,
`endif
    output logic            valid,
    output logic [ID_W-1:0] idx
);
`ifdef TIMER_INT_RR_EN
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] j;
    // scan backwards from the farthest slot so the entry nearest rr_ptr wins
    always_comb begin
        valid = |pend;
        idx = '0;
        sum = '0;
        j = '0;
        for (int k = N_CH-1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            j = (sum >= (ID_W+1)'(N_CH)) ? ID_W'(sum - (ID_W+1)'(N_CH)) : ID_W'(sum);
            if (pend[j]) idx = j;
        end
    end
`else
    always_comb begin
        valid = |pend;
        idx = '0;
        for (int i = N_CH-1; i >= 0; i--)
            if (pend[i]) idx = ID_W'(i);
    end
`endif
endmodule

// File: rtl/timer_int_arbiter.sv
// timer_int_arbiter: shares one CPU irq among N_CH timer channels with ack/clear/wait-low handshake; TIMER_INT_RR_EN selects round-robin
module timer_int_arbiter
    import timer_int_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int ID_W    = 2,
    parameter int TMO_CYC = 15
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [N_CH-1:0] ch_int,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            irq_ack,
    input  logic            tmo_err_clr,
    output logic            irq,
    output logic [ID_W-1:0] irq_id,
    output logic [N_CH-1:0] int_clr,
    output logic            busy,
    output logic            tmo_err
);
    state_t            state, state_nxt;
    logic [N_CH-1:0]   pend;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic              timeout, win_vld;
    logic [ID_W-1:0]   win_idx;
`ifdef TIMER_INT_RR_EN
    logic [ID_W-1:0]   rr_ptr;
`endif

    assign pend = ch_int & ~ch_mask;
    assign busy = (state != IDLE);

    timer_int_prio_sel #(.N_CH(N_CH), .ID_W(ID_W)) u_sel (
        .pend  (pend),
`ifdef TIMER_INT_RR_EN
        .rr_ptr(rr_ptr),
`endif
        .valid (win_vld),
        .idx   (win_idx)
    );

    always_comb begin
        state_nxt = state;
        timeout = 1'b0;
        tmo_nxt = (tmo_cnt == TMO_W'(TMO_CYC)) ? tmo_cnt : tmo_cnt + 1'b1;
        case (state)
            IDLE:     state_nxt = win_vld ? ASSERT : IDLE;
            ASSERT:   state_nxt = irq_ack ? CLEAR : (pend[irq_id] ? ASSERT : IDLE);
            CLEAR:    state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                timeout = ch_int[irq_id] && (tmo_nxt == TMO_W'(TMO_CYC));
                state_nxt = (!ch_int[irq_id] || timeout) ? IDLE : WAIT_LOW;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
            int_clr <= '0;
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            irq     <= (state_nxt == ASSERT);
            int_clr <= (state_nxt == CLEAR) ? (N_CH'(1) << irq_id) : '0;
            if (state == IDLE && win_vld) irq_id <= win_idx;
            tmo_cnt <= (state == CLEAR) ? '0 : (state == WAIT_LOW) ? tmo_nxt : tmo_cnt;
            tmo_err <= timeout | (tmo_err & ~tmo_err_clr);
        end
    end

`ifdef TIMER_INT_RR_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            rr_ptr <= '0;
        else if (state == CLEAR)
            rr_ptr <= (irq_id == ID_W'(N_CH-1)) ? '0 : irq_id + 1'b1;
    end
`endif
endmodule

// File: tb/tb_timer_int_arbiter.sv
// tb_timer_int_arbiter: directed self-checking bench for timer_int_arbiter
module tb_timer_int_arbiter;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] ch_int = '0;
    logic [3:0] ch_mask = '0;
    logic       irq_ack = 1'b0;
    logic       tmo_err_clr = 1'b0;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] int_clr;
    logic       busy;
    logic       tmo_err;
    int         n_tests = 0;
    int         n_fail = 0;

    timer_int_arbiter #(.N_CH(4), .ID_W(2), .TMO_CYC(15)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ch_int     (ch_int),
        .ch_mask    (ch_mask),
        .irq_ack    (irq_ack),
        .tmo_err_clr(tmo_err_clr),
        .irq        (irq),
        .irq_id     (irq_id),
        .int_clr    (int_clr),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_irq(input int max);
        int n = 0;
        while (irq !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk("irq_wait", {31'd0, irq}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        chk("rst_irq", {31'd0, irq}, 0);
        chk("rst_id", {30'd0, irq_id}, 0);
        chk("rst_clr", {28'd0, int_clr}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tmo", {31'd0, tmo_err}, 0);
        sys_rst = 1'b0;
        step();

        ch_int = 4'b0100;
        step();
        chk("t1_irq", {31'd0, irq}, 1);
        chk("t1_id", {30'd0, irq_id}, 2);
        chk("t1_busy", {31'd0, busy}, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t1_clr", {28'd0, int_clr}, 32'h4);
        chk("t1_irq_lo", {31'd0, irq}, 0);
        ch_int = 4'b0000;
        step();
        chk("t1_clr_1cyc", {28'd0, int_clr}, 0);
        chk("t1_busy_wl", {31'd0, busy}, 1);
        step();
        chk("t1_idle", {31'd0, busy}, 0);

`ifndef TIMER_INT_RR_EN
        ch_int = 4'b1010;
        step();
        chk("t2_id1", {30'd0, irq_id}, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t2_clr1", {28'd0, int_clr}, 32'h2);
        ch_int = 4'b1000;
        repeat (2) step();
        chk("t2_idle", {31'd0, busy}, 0);
        step();
        chk("t2_irq3", {31'd0, irq}, 1);
        chk("t2_id3", {30'd0, irq_id}, 3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t2_clr3", {28'd0, int_clr}, 32'h8);
        ch_int = 4'b0000;
        repeat (2) step();
        chk("t2_done", {31'd0, busy}, 0);
`endif

        ch_int = 4'b0001;
        step();
        chk("t3_irq", {31'd0, irq}, 1);
        ch_mask = 4'b0001;
        step();
        chk("t3_withdraw", {31'd0, irq}, 0);
        chk("t3_busy", {31'd0, busy}, 0);
        chk("t3_noclr", {28'd0, int_clr}, 0);
        step();
        chk("t3_noclr2", {28'd0, int_clr}, 0);
        ch_mask = 4'b0000;
        ch_int = 4'b0000;
        step();

        ch_int = 4'b0001;
        step();
        chk("t4_id", {30'd0, irq_id}, 0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t4_clr", {28'd0, int_clr}, 32'h1);
        step();
        repeat (14) step();
        chk("t4_wl_busy", {31'd0, busy}, 1);
        chk("t4_wl_tmo", {31'd0, tmo_err}, 0);
        step();
        chk("t4_tmo_idle", {31'd0, busy}, 0);
        chk("t4_tmo_err", {31'd0, tmo_err}, 1);
        step();
        chk("t4_reserve", {31'd0, irq}, 1);
        chk("t4_reserve_id", {30'd0, irq_id}, 0);
        ch_int = 4'b0000;
        step();
        chk("t4_drop", {31'd0, irq}, 0);
        chk("t4_sticky", {31'd0, tmo_err}, 1);
        tmo_err_clr = 1'b1;
        step();
        tmo_err_clr = 1'b0;
        chk("t4_tmo_clr", {31'd0, tmo_err}, 0);

        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t5_idle_ack", {31'd0, busy}, 0);
        chk("t5_idle_clr", {28'd0, int_clr}, 0);
        ch_int = 4'b0100;
        step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t5_wl_busy", {31'd0, busy}, 1);
        chk("t5_wl_clr", {28'd0, int_clr}, 0);
        ch_int = 4'b0000;
        step();
        chk("t5_done", {31'd0, busy}, 0);

`ifdef TIMER_INT_RR_EN
        ch_int = 4'b1111;
        for (int e = 0; e < 5; e++) begin
            wait_irq(40);
            chk("rr_order", {30'd0, irq_id}, e % 4);
            irq_ack = 1'b1;
            step();
            irq_ack = 1'b0;
        end
        ch_int = 4'b0000;
        repeat (3) step();
        chk("rr_done", {31'd0, busy}, 0);
        tmo_err_clr = 1'b1;
        step();
        tmo_err_clr = 1'b0;
`endif

        ch_int = 4'b0010;
        wait_irq(4);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t6_clr", {28'd0, int_clr}, 32'h2);
        sys_rst = 1'b1;
        #1;
        chk("t6_rst_clr", {28'd0, int_clr}, 0);
        chk("t6_rst_irq", {31'd0, irq}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_id", {30'd0, irq_id}, 0);
        ch_int = 4'b0000;
        step();
        sys_rst = 1'b0;
        step();
        chk("t6_after", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
